uart_rx: RTL and testbench

- Serial receiver for the team's UART link. Deserialises one 11-bit frame into a parallel byte: start bit, DATA_WIDTH data bits, parity bit, stop bit.
- Sits between the external RX pin and the byte-level consumer logic.
- Samples the line at OVERSAMPLE ticks per bit. The baud tick is supplied externally by the shared baud generator.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM state encoding and parity helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;
    localparam int unsigned FRAME_BITS      = UART_DATA_WIDTH + 3;
    localparam int unsigned PAR_MAX_W       = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Even parity: zero-extension of narrower words leaves the result unchanged.
    function automatic logic parity_even(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a reset preset value.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH data bits (MSB first), even parity, stop.
// Oversampled by an external sample_tick; the FSM only moves on tick cycles.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic                  s_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    logic                  w_rx_s;
    uart_state_t           r_state;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_sreg;
    logic                  r_par_bit;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (s_in),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_sreg     <= '0;
            r_par_bit  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (sample_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_rx_s) begin
                            r_state    <= ST_START;
                            r_tick_cnt <= '0;
                            busy       <= 1'b1;
                        end
                    end
                    // Re-check the line mid start bit to reject short glitches.
                    ST_START: begin
                        if (r_tick_cnt == TICK_HALF) begin
                            r_tick_cnt <= '0;
                            if (w_rx_s) begin
                                r_state <= ST_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                r_state   <= ST_DATA;
                                r_bit_cnt <= '0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            r_sreg     <= {r_sreg[DATA_WIDTH-2:0], w_rx_s};
                            if (r_bit_cnt == BIT_LAST) begin
                                r_state <= ST_PARITY;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            r_par_bit  <= w_rx_s;
                            r_state    <= ST_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                        end
                    end
                    // Frames with errors are still delivered; the flags qualify them.
                    ST_STOP: begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            data_out   <= r_sreg;
                            parity_err <= r_par_bit ^ parity_even(PAR_MAX_W'(r_sreg));
                            frame_err  <= ~w_rx_s;
                            data_valid <= 1'b1;
                            r_state    <= ST_IDLE;
                            busy       <= 1'b0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected words, a monitor checks each data_valid.
module tb_uart_rx;

    localparam int unsigned OS = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       sample_tick;
    logic       s_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int   total;
    int   bad;
    int   tick_div;
    int   tcnt;
    exp_t exp_q[$];

    uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .s_in        (s_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick generator: one tick every tick_div clocks, updated on the falling edge.
    initial begin
        sample_tick = 1'b0;
        tcnt = 0;
        forever begin
            @(negedge clk);
            tcnt = tcnt + 1;
            if (tcnt >= tick_div) tcnt = 0;
            sample_tick = (tcnt == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!sample_tick) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        s_in = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input logic exp_pe, input logic exp_fe);
        exp_t e;
        e.d  = d;
        e.pe = exp_pe;
        e.fe = exp_fe;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
    endtask

    // Monitor: pop and compare on every data_valid, and insist on single-cycle pulses.
    initial begin
        logic prev_dv;
        exp_t e;
        prev_dv = 1'b0;
        forever begin
            @(negedge clk);
            if (data_valid) begin
                check("dv_single_pulse", 32'(prev_dv), 32'd0);
                if (!prev_dv) begin
                    if (exp_q.size() == 0) begin
                        total = total + 1;
                        bad   = bad + 1;
                        $display("FAIL unexpected_dv: data_out=0x%0h with no frame pending", data_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_out",   32'(data_out),   32'(e.d));
                        check("parity_err", 32'(parity_err), 32'(e.pe));
                        check("frame_err",  32'(frame_err),  32'(e.fe));
                    end
                end
            end
            prev_dv = data_valid;
        end
    end

    initial begin
        int guard;
        total    = 0;
        bad      = 0;
        tick_div = 1;
        rst      = 1'b1;
        s_in     = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data_out",   32'(data_out),   32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_frame_err",  32'(frame_err),  32'h0);
        check("rst_busy",       32'(busy),       32'h0);

        // Clean, parity-error and framing-error frames, each followed by idle line.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check("idle_busy", 32'(busy), 32'h0);

        // Glitch shorter than half a bit must be rejected.
        @(negedge clk);
        s_in = 1'b0;
        wait_ticks(3);
        @(negedge clk);
        check("glitch_busy_high", 32'(busy), 32'h1);
        s_in = 1'b1;
        guard = 0;
        while (busy && guard < 12) begin
            wait_ticks(1);
            @(negedge clk);
            guard++;
        end
        check("glitch_busy_low", 32'(busy), 32'h0);
        send_bit(1'b1);

        // Reset after four data bits aborts the frame and clears the outputs.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        rst  = 1'b1;
        s_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(3 * OS);
        @(negedge clk);
        check("midrst_data_out",   32'(data_out),   32'h0);
        check("midrst_data_valid", 32'(data_valid), 32'h0);
        check("midrst_parity_err", 32'(parity_err), 32'h0);
        check("midrst_frame_err",  32'(frame_err),  32'h0);
        check("midrst_busy",       32'(busy),       32'h0);

        // Back-to-back frames with ticks on every fourth clock.
        @(negedge clk);
        tick_div = 4;
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
